// File: rtl/rsp_s1_prep_pkg.sv
// Shared types and constants for the s1 prep phase generator and its entry table.
package rsp_s1_prep_pkg;

    localparam int unsigned PREP_PHASE_W = 16;

    typedef logic [PREP_PHASE_W-1:0] phase_t;

    typedef struct packed {
        phase_t start;
        phase_t step;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        RUN
    } state_t;

    localparam logic MODE_CONTIG = 1'b0;
    localparam logic MODE_PAIRED = 1'b1;

endpackage

// File: rtl/rsp_s1_prep_entry_regfile.sv
// Phase entry table: one write port, a config read port and a frame-select read port,
// both with 1-cycle registered read. Kept separate so it can become an spram macro.
module rsp_s1_prep_entry_regfile #(
    parameter int unsigned ENTRY_NUM = 32,
    parameter int unsigned ENTRY_AW  = $clog2(ENTRY_NUM),
    parameter int unsigned DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ENTRY_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ENTRY_AW-1:0] rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                sel_rd_en,
    input  logic [ENTRY_AW-1:0] sel_addr,
    output logic [DATA_W-1:0]   sel_data
);

    logic [DATA_W-1:0] mem_q [ENTRY_NUM];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] sel_data_q;

    // Contents are not reset; the write counter in the top tracks validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-write contents on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            sel_data_q <= '0;
        end else begin
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
            if (sel_rd_en) begin
                sel_data_q <= mem_q[sel_addr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign sel_data = sel_data_q;

endmodule

// File: rtl/rsp_s1_prep_phase_gen_mlane.sv
// Multi-lane phase generator: selects a {start, step} entry per frame and emits LANES
// accumulated phase words per valid input beat.
module rsp_s1_prep_phase_gen_mlane
    import rsp_s1_prep_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned ENTRY_NUM = 32,
    parameter int unsigned ENTRY_AW  = $clog2(ENTRY_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_wr_en,
    input  logic                     i_cfg_rd_en,
    input  logic [ENTRY_AW-1:0]      i_cfg_addr,
    input  logic [2*PHASE_W-1:0]     i_cfg_wdata,
    output logic [2*PHASE_W-1:0]     o_cfg_rdata,
    input  logic                     i_mode,
    input  logic [ENTRY_AW-1:0]      i_entry_sel,
    input  logic                     i_start,
    input  logic                     i_data_valid,
    input  logic                     i_data_last,
    output logic [LANES*PHASE_W-1:0] o_phase,
    output logic                     o_valid,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_tbl_ready,
    output logic                     o_err
);

    localparam int unsigned LANE_LG = $clog2(LANES);
    localparam int unsigned CNT_W   = ENTRY_AW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ENTRY_NUM);

    typedef logic [PHASE_W-1:0] lane_t;

    state_t                        state_q, state_d;
    logic                          mode_q, mode_d;
    logic                          sel_rd_en;
    logic [2*PHASE_W-1:0]          sel_data;
    lane_t                         sel_start, sel_step;
    logic [LANES-1:0][PHASE_W-1:0] acc_q, acc_d;
    logic [LANES-1:0][PHASE_W-1:0] phase_q, phase_d;
    lane_t                         adv_q, adv_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          err_q, err_d;
    logic [CNT_W-1:0]              wr_cnt_q;
    logic                          tbl_ready;

    // Constant multiply by a small lane index, unrolled into shifted adds.
    function automatic lane_t mul_small(input lane_t x, input int unsigned m);
        lane_t r;
        r = '0;
        for (int unsigned b = 0; b < LANE_LG; b++) begin
            if (m[b]) begin
                r = r + lane_t'(x << b);
            end
        end
        return r;
    endfunction

    rsp_s1_prep_entry_regfile #(
        .ENTRY_NUM (ENTRY_NUM),
        .ENTRY_AW  (ENTRY_AW),
        .DATA_W    (2 * PHASE_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (i_cfg_wr_en),
        .wr_addr   (i_cfg_addr),
        .wr_data   (i_cfg_wdata),
        .rd_en     (i_cfg_rd_en),
        .rd_addr   (i_cfg_addr),
        .rd_data   (o_cfg_rdata),
        .sel_rd_en (sel_rd_en),
        .sel_addr  (i_entry_sel),
        .sel_data  (sel_data)
    );

    // The select port register holds the frame's entry until the next start.
    assign {sel_start, sel_step} = sel_data;
    assign tbl_ready = (wr_cnt_q == CNT_FULL);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sel_rd_en = 1'b0;
        acc_d     = acc_q;
        adv_d     = adv_q;
        phase_d   = phase_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (tbl_ready) begin
                        mode_d    = i_mode;
                        sel_rd_en = 1'b1;
                        state_d   = PREP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (i_data_valid) begin
                    err_d = 1'b1;
                end
            end
            PREP: begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    acc_d[k] = sel_start + ((mode_q == MODE_PAIRED) ?
                                            mul_small(sel_step, k >> 1) :
                                            mul_small(sel_step, k));
                end
                adv_d   = (mode_q == MODE_PAIRED) ? lane_t'(sel_step << (LANE_LG - 1)) :
                                                    lane_t'(sel_step << LANE_LG);
                state_d = RUN;
                if (i_data_valid) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                if (i_start && !(i_data_valid && i_data_last)) begin
                    // Abort: drop the frame and restart from a freshly sampled entry.
                    err_d     = 1'b1;
                    mode_d    = i_mode;
                    sel_rd_en = 1'b1;
                    state_d   = PREP;
                end else if (i_data_valid) begin
                    phase_d = acc_q;
                    valid_d = 1'b1;
                    last_d  = i_data_last;
                    for (int unsigned k = 0; k < LANES; k++) begin
                        acc_d[k] = acc_q[k] + adv_q;
                    end
                    if (i_data_last) begin
                        state_d = IDLE;
                        if (i_start) begin
                            mode_d    = i_mode;
                            sel_rd_en = 1'b1;
                            state_d   = PREP;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_CONTIG;
            acc_q   <= '0;
            adv_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            adv_q   <= adv_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else if (i_cfg_wr_en && !tbl_ready) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    assign o_phase     = phase_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != IDLE);
    assign o_tbl_ready = tbl_ready;

endmodule

// File: tb/tb_rsp_s1_prep_phase_gen_mlane.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run
// against a closed-form phase model.
module tb_rsp_s1_prep_phase_gen_mlane;

    localparam int L = 4;
    localparam int PW = 16;
    localparam int EN = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_cfg_wr_en, i_cfg_rd_en;
    logic [AW-1:0]   i_cfg_addr;
    logic [2*PW-1:0] i_cfg_wdata;
    logic [2*PW-1:0] o_cfg_rdata;
    logic            i_mode;
    logic [AW-1:0]   i_entry_sel;
    logic            i_start, i_data_valid, i_data_last;
    logic [L*PW-1:0] o_phase;
    logic            o_valid, o_last, o_busy, o_tbl_ready, o_err;

    rsp_s1_prep_phase_gen_mlane #(
        .LANES     (L),
        .PHASE_W   (PW),
        .ENTRY_NUM (EN),
        .ENTRY_AW  (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_wr_en  (i_cfg_wr_en),
        .i_cfg_rd_en  (i_cfg_rd_en),
        .i_cfg_addr   (i_cfg_addr),
        .i_cfg_wdata  (i_cfg_wdata),
        .o_cfg_rdata  (o_cfg_rdata),
        .i_mode       (i_mode),
        .i_entry_sel  (i_entry_sel),
        .i_start      (i_start),
        .i_data_valid (i_data_valid),
        .i_data_last  (i_data_last),
        .o_phase      (o_phase),
        .o_valid      (o_valid),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_tbl_ready  (o_tbl_ready),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        md;
        logic [4:0]  sel;
        logic        v;
        logic        l;
        logic        ev;
        logic        el;
        logic        ee;
        logic        eb;
        logic [63:0] eph;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_tbl[EN];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic st, input logic md, input logic [4:0] sel,
                             input logic v, input logic l);
        i_start      = st;
        i_mode       = md;
        i_entry_sel  = sel;
        i_data_valid = v;
        i_data_last  = l;
    endtask

    task automatic add(input logic st, input logic md, input logic [4:0] sel, input logic v,
                       input logic l, input logic ev, input logic el, input logic ee,
                       input logic eb, input logic [63:0] eph);
        vec_t x;
        x.st = st; x.md = md; x.sel = sel; x.v = v; x.l = l;
        x.ev = ev; x.el = el; x.ee = ee; x.eb = eb; x.eph = eph;
        vecs.push_back(x);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        i_cfg_wr_en = 1'b1;
        i_cfg_addr  = a;
        i_cfg_wdata = d;
        tick();
        i_cfg_wr_en = 1'b0;
        m_tbl[a]    = d;
    endtask

    task automatic load_table(input bit rnd);
        logic [31:0] d;
        for (int a = 0; a < EN; a++) begin
            d = rnd ? $urandom : {16'h1000 + 16'(a), 16'h0010 + 16'(a)};
            wr(5'(a), d);
            chk($sformatf("tbl_ready_after_wr%0d", a), 64'(o_tbl_ready), 64'(a == EN - 1));
        end
    endtask

    // Lane k, beat n of a frame: S + (lane multiple + n * per-beat multiple) * D.
    function automatic logic [63:0] model_beat(input logic [15:0] s, input logic [15:0] d,
                                               input logic m, input int n);
        logic [63:0] r;
        int          mult;
        int          val;
        for (int k = 0; k < L; k++) begin
            mult = (m ? k / 2 : k) + n * (m ? L / 2 : L);
            val = int'(s) + mult * int'(d);
            r[k*16 +: 16] = val[15:0];
        end
        return r;
    endfunction

    initial begin
        int          stage;
        int          beat;
        logic [15:0] fs, fd;
        logic        fm;
        logic [63:0] exp_phase;
        logic [31:0] exp_rdata;
        logic        e_valid, e_last, e_err;
        logic        st, md, v, l, wr_en, rd_en;
        logic [4:0]  sel, addr;
        logic [31:0] wdata;

        rst_n = 1'b0;
        i_cfg_wr_en = 1'b0; i_cfg_rd_en = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0;
        set_frame(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ready", 64'(o_tbl_ready), 64'd0);
        chk("rst_phase", o_phase, 64'd0);
        chk("rst_rdata", 64'(o_cfg_rdata), 64'd0);
        rst_n = 1'b1;
        tick();

        // Start before the table is loaded, then a stray beat in IDLE.
        set_frame(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
        tick();
        chk("early_start_err", 64'(o_err), 64'd1);
        chk("early_start_busy", 64'(o_busy), 64'd0);
        set_frame(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("idle_beat_err", 64'(o_err), 64'd1);
        chk("idle_beat_valid", 64'(o_valid), 64'd0);
        set_frame(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("err_pulse_clears", 64'(o_err), 64'd0);

        load_table(1'b0);
        i_cfg_rd_en = 1'b1; i_cfg_addr = 5'd5;
        tick();
        chk("read_addr5", 64'(o_cfg_rdata), 64'h1005_0015);
        i_cfg_rd_en = 1'b0; i_cfg_addr = 5'd9;
        tick();
        chk("rdata_holds", 64'(o_cfg_rdata), 64'h1005_0015);
        i_cfg_rd_en = 1'b1; i_cfg_wr_en = 1'b1; i_cfg_addr = 5'd5; i_cfg_wdata = 32'hABCD_0001;
        tick();
        m_tbl[5] = 32'hABCD_0001;
        chk("rw_collision_old", 64'(o_cfg_rdata), 64'h1005_0015);
        i_cfg_wr_en = 1'b0;
        tick();
        chk("read_after_write", 64'(o_cfg_rdata), 64'hABCD_0001);
        i_cfg_rd_en = 1'b0;
        wr(5'd1, 32'h0100_0004);
        wr(5'd2, 32'hFFF8_0004);

        // st md sel v l | valid last err busy phase
        add(1, 0, 1, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 64'h010C_0108_0104_0100);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 64'h011C_0118_0114_0110);
        add(0, 0, 0, 1, 1, 1, 1, 0, 0, 64'h012C_0128_0124_0120);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 64'h0104_0104_0100_0100);
        add(0, 0, 0, 1, 1, 1, 1, 0, 0, 64'h010C_010C_0108_0108);
        add(1, 0, 2, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 64'h0004_0000_FFFC_FFF8);
        add(0, 0, 0, 1, 1, 1, 1, 0, 0, 64'h0014_0010_000C_0008);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 64'h0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 64'h010C_0108_0104_0100);
        add(1, 0, 2, 0, 0, 0, 0, 1, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 64'h0004_0000_FFFC_FFF8);
        add(1, 1, 1, 1, 1, 1, 1, 0, 1, 64'h0014_0010_000C_0008);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 0, 1, 1, 1, 1, 0, 0, 64'h0104_0104_0100_0100);

        foreach (vecs[i]) begin
            set_frame(vecs[i].st, vecs[i].md, vecs[i].sel, vecs[i].v, vecs[i].l);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_last", i), 64'(o_last), 64'(vecs[i].el));
            chk($sformatf("vec%0d_err", i), 64'(o_err), 64'(vecs[i].ee));
            chk($sformatf("vec%0d_busy", i), 64'(o_busy), 64'(vecs[i].eb));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_phase", i), o_phase, vecs[i].eph);
            end
        end
        set_frame(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset in the middle of a running frame.
        set_frame(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
        tick();
        set_frame(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        set_frame(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("pre_reset_valid", 64'(o_valid), 64'd1);
        set_frame(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrun_rst_valid", 64'(o_valid), 64'd0);
        chk("midrun_rst_busy", 64'(o_busy), 64'd0);
        chk("midrun_rst_ready", 64'(o_tbl_ready), 64'd0);
        chk("midrun_rst_phase", o_phase, 64'd0);
        chk("midrun_rst_rdata", 64'(o_cfg_rdata), 64'd0);
        rst_n = 1'b1;
        set_frame(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
        tick();
        chk("post_rst_start_err", 64'(o_err), 64'd1);
        chk("post_rst_start_busy", 64'(o_busy), 64'd0);
        set_frame(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        load_table(1'b1);

        stage = 0; beat = 0; fs = '0; fd = '0; fm = 1'b0;
        exp_phase = '0; exp_rdata = '0;
        for (int c = 0; c < 3000; c++) begin
            st    = ($urandom_range(0, 15) == 0);
            md    = 1'($urandom);
            sel   = 5'($urandom);
            v     = ($urandom_range(0, 2) != 0);
            l     = ($urandom_range(0, 5) == 0);
            wr_en = ($urandom_range(0, 7) == 0);
            rd_en = ($urandom_range(0, 3) == 0);
            addr  = 5'($urandom);
            wdata = $urandom;
            set_frame(st, md, sel, v, l);
            i_cfg_wr_en = wr_en; i_cfg_rd_en = rd_en; i_cfg_addr = addr; i_cfg_wdata = wdata;

            e_valid = 1'b0; e_last = 1'b0; e_err = 1'b0;
            case (stage)
                0: begin
                    if (st) begin
                        fs = m_tbl[sel][31:16]; fd = m_tbl[sel][15:0]; fm = md; stage = 1;
                    end
                    if (v) e_err = 1'b1;
                end
                1: begin
                    stage = 2; beat = 0;
                    if (v) e_err = 1'b1;
                end
                default: begin
                    if (st && !(v && l)) begin
                        e_err = 1'b1;
                        fs = m_tbl[sel][31:16]; fd = m_tbl[sel][15:0]; fm = md; stage = 1;
                    end else if (v) begin
                        exp_phase = model_beat(fs, fd, fm, beat);
                        beat++;
                        e_valid = 1'b1;
                        e_last = l;
                        if (l) begin
                            stage = 0;
                            if (st) begin
                                fs = m_tbl[sel][31:16]; fd = m_tbl[sel][15:0]; fm = md;
                                stage = 1;
                            end
                        end
                    end
                end
            endcase
            if (rd_en) exp_rdata = m_tbl[addr];
            if (wr_en) m_tbl[addr] = wdata;

            tick();
            chk($sformatf("rnd%0d_valid", c), 64'(o_valid), 64'(e_valid));
            chk($sformatf("rnd%0d_last", c), 64'(o_last), 64'(e_last));
            chk($sformatf("rnd%0d_err", c), 64'(o_err), 64'(e_err));
            chk($sformatf("rnd%0d_busy", c), 64'(o_busy), 64'(stage != 0));
            chk($sformatf("rnd%0d_phase", c), o_phase, exp_phase);
            chk($sformatf("rnd%0d_rdata", c), 64'(o_cfg_rdata), 64'(exp_rdata));
            chk($sformatf("rnd%0d_ready", c), 64'(o_tbl_ready), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsp_s1_prep_phase_gen_mlane.md
Name: rsp_s1_prep_phase_gen_mlane

Overview:
- Parametrised successor to the s1 prep phase generator.
- Holds a table of ENTRY_NUM phase entries, each {start phase, step}.
- On each frame start it selects one entry and produces LANES phase words per valid input beat, using a per-lane accumulator that advances every beat.
- Sits between the prep config bus and the twiddle/rotator lanes of rsp_s1_prep.

Parameters:
- LANES, 4, number of parallel phase outputs; power of 2, 2..16.
- PHASE_W, 16, phase/step width; all arithmetic is mod 2^PHASE_W.
- ENTRY_NUM, 32, number of table entries; power of 2.
- ENTRY_AW, $clog2(ENTRY_NUM), entry address width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_cfg_wr_en  in  1  table write strobe.
- i_cfg_rd_en  in  1  table read strobe.
- i_cfg_addr  in  ENTRY_AW  table address.
- i_cfg_wdata  in  2*PHASE_W  write data: [2*PHASE_W-1:PHASE_W] = start, [PHASE_W-1:0] = step.
- o_cfg_rdata  out  2*PHASE_W  read data.
- i_mode  in  1  0 = contiguous lanes, 1 = paired lanes; sampled at i_start.
- i_entry_sel  in  ENTRY_AW  entry used by the next frame; sampled at i_start.
- i_start  in  1  frame start pulse.
- i_data_valid  in  1  input beat valid.
- i_data_last  in  1  last beat of frame; qualified by i_data_valid.
- o_phase  out  LANES*PHASE_W  lane k occupies bits [k*PHASE_W +: PHASE_W].
- o_valid  out  1  phase valid.
- o_last  out  1  last beat.
- o_busy  out  1  state is not IDLE.
- o_tbl_ready  out  1  all entries have been written at least once.
- o_err  out  1  1-cycle pulse on a protocol error.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; write counter = 0; table contents undefined; accumulators = 0.
- Table:
  - A write takes effect on the next cycle.
  - A read returns data on o_cfg_rdata 1 cycle after i_cfg_rd_en; o_cfg_rdata holds between reads.
  - If read and write hit the same address in the same cycle, the read returns the old data.
  - The write counter increments on every write and saturates at ENTRY_NUM. o_tbl_ready = (count == ENTRY_NUM); it stays high until reset.
- FSM: IDLE -> PREP -> RUN -> IDLE.
- IDLE:
  - i_start with o_tbl_ready=1: latch i_entry_sel and i_mode, read the entry, go to PREP.
  - i_start with o_tbl_ready=0: ignored, o_err pulses.
- PREP (exactly 1 cycle), with S = entry start, D = entry step:
  - Mode 0: acc[k] = S + k*D; adv = LANES*D.
  - Mode 1: acc[k] = S + (k>>1)*D; adv = (LANES/2)*D.
  - Multiplies are by constants; implement them as shift/add.
  - Go to RUN.
- RUN:
  - Each cycle with i_data_valid: o_phase <= acc, o_valid <= 1, o_last <= i_data_last, acc[k] <= acc[k] + adv. Output latency is 1 cycle from i_data_valid.
  - o_valid deasserts on the cycle after a beat with no i_data_valid.
  - A valid beat with last returns to IDLE.
- i_data_valid in IDLE or PREP: ignored, o_err pulses, no output.
- i_start in RUN:
  - Without a valid last beat: abort the frame (no o_last), o_err pulses, go to PREP with a newly sampled entry and mode.
  - Coinciding with a valid last beat: emit that beat normally (o_last=1), then go to PREP, not IDLE.
- Table writes during RUN are allowed. The running frame uses its latched copy, so a write to the selected entry affects only the next frame.
- Wrap-around: accumulators wrap silently mod 2^PHASE_W; there is no saturation.
- Reset mid-frame: immediate return to the reset state; o_tbl_ready clears and the table must be reloaded.

Decomposition:
- Package rsp_s1_prep_pkg holds:
  - the phase_t typedef (logic [PHASE_W-1:0]);
  - the entry_t struct {phase_t start; phase_t step};
  - the FSM enum {IDLE, PREP, RUN};
  - the mode constants MODE_CONTIG = 0 and MODE_PAIRED = 1.
- Sub-module rsp_s1_prep_entry_regfile: ENTRY_NUM x entry_t, one write port, 1-cycle read. It is separated so it can later be swapped for an spram macro.

Test Plan:
- Load: write entries 0..31 with start = 0x1000+addr, step = 0x0010+addr -> o_tbl_ready rises on the cycle after the 32nd write; read addr 5 -> 0x1005_0015 one cycle after i_cfg_rd_en.
- Mode 0, LANES=4: select entry {S=0x0100, D=0x0004}; start; 3 valid beats -> beat 0 lanes {0x0100,0x0104,0x0108,0x010C}, beat 1 {0x0110,...}, beat 2 {0x0120,...}.
  - The last beat has o_last=1 and o_busy falls the next cycle.
- Mode 1 with the same entry -> beat 0 {0x0100,0x0100,0x0104,0x0104}; beat 1 adds 0x0008 to each lane.
- Wrap: {S=0xFFF8, D=0x0004}, mode 0 -> beat 0 lanes {0xFFF8,0xFFFC,0x0000,0x0004}, beat 1 {0x0008,...}.
- Errors:
  - Start before the table is fully loaded -> o_err pulse, o_busy stays 0.
  - Valid beat while in IDLE -> o_err pulse, no o_valid.
  - Start in mid-frame without last -> o_err pulse, no o_last, new frame restarts from the new entry.
- Start coinciding with a valid last beat -> o_last=1 on that beat, then PREP; the next frame's first beat equals the new entry's start value. Assert reset in mid-RUN -> all outputs 0 on the next edge and o_tbl_ready=0.
